ram_arbiter: RTL
================

# ram_arbiter

Shares the single byte-wide external RAM bus between the instruction-fetch path (I-cache refill, 32-bit word reads) and the MEM stage (1/2/4-byte loads and stores). It serialises each request into per-byte bus cycles, reassembles little-endian read data, sign- or zero-extends loads, and returns a one-cycle `ready` pulse. It sits between `cache_i`/`stage_mem` and the top-level `mem_a`/`mem_din`/`mem_dout`/`mem_wr` pins, and honours the global `rdy` pause.

## Interface
- `FAVOR_MEM`, 1: on a same-cycle request from both ports in IDLE, 1 = MEM port wins, 0 = IF port wins.
- `clock` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-low.
- `rdy` in 1: low = pause.
- `ram_rw` out 1: 1 = write byte this cycle.
- `ram_addr` out 32: byte address.
- `ram_w_data` out 8: write byte.
- `ram_r_data` in 8: read byte; the byte at the address driven in cycle C is valid in C+1.
- `if_read` in 1, `if_addr` in 32: IF word-read request, held until `if_ready`.
- `if_ready` out 1, `if_data` out 32: one-cycle completion pulse and data.
- `if_busy` out 1: arbiter is serving the MEM port.
- `mem_read`, `mem_write` in 1: MEM request, held until `mem_ready`.
- `mem_addr` in 32, `mem_data_i` in 32, `mem_length` in 3, `mem_signed` in 1: request arguments.
- `mem_ready` out 1, `mem_data_o` out 32: completion pulse and load result; `mem_data_o` is 0 for stores.
- `mem_busy` out 1: arbiter is serving the IF port.

## Operation
- States:
  - IDLE: samples requests.
  - RD: issue and capture read bytes.
  - WR: issue write bytes.
  - DONE: `ready` pulse; requests are ignored.
- Transitions:
  - IDLE→RD or WR on a request; priority per `FAVOR_MEM`.
  - `mem_write` with `mem_read` both high is treated as a write.
  - The grant is non-preemptive.
  - RD→DONE after the last byte is captured.
  - WR→DONE after the last byte is written.
  - DONE→IDLE always.
- Length:
  - `mem_length` 1, 2 and 4 are legal; any other value is treated as 4.
  - IF requests are always 4.
- Counters:
  - `issue_idx` and `recv_idx` are 3-bit, range 0..length.
  - `ram_addr` = base + `issue_idx`; 32-bit add, wraps at 2^32 and is not checked.
- Read:
  - Byte k is placed at data[8k+7:8k].
  - Signed length 1 extends bit 7; signed length 2 extends bit 15; otherwise zero-fill.
  - `if_data` is never extended.
- Write: byte k = `mem_data_i`[8k+7:8k], `ram_rw`=1, low byte first.
- Busy:
  - `if_busy` is high in RD/WR/DONE owned by MEM.
  - `mem_busy` is high in RD/WR/DONE owned by IF.
  - Both are 0 in IDLE.
- Pause:
  - While `rdy`=0: no counter, data or state change; `ram_rw` is gated to 0 combinationally.
  - While `rdy`=0 and on the first cycle after `rdy` returns high: no byte is captured, and `issue_idx` rewinds to `recv_idx`, so the next driven address is base+`recv_idx`.
  - A paused write re-drives the same byte.
- Reset (`reset`=0, any state):
  - Next cycle: IDLE; all outputs and counters 0.
  - An in-flight request is dropped; the requester must reissue.

## Timing
- Reset values: `ram_rw`, `ram_addr`, `ram_w_data`, `if_ready`, `if_data`, `if_busy`, `mem_ready`, `mem_data_o`, `mem_busy` are all 0.
- All outputs are registered except the `rdy` gating of `ram_rw`.
- n-byte read, request sampled in IDLE at cycle T:
  - Addresses driven in T+1..T+n.
  - Bytes captured in T+2..T+n+1.
  - `ready` and data valid in T+n+2 (word read: T+6).
- n-byte write sampled at T:
  - Bytes written in T+1..T+n.
  - `ready` in T+n+1.
- DONE lasts exactly one cycle; the earliest next grant is sampled at DONE+1.
- The requester may drop its request in the `ready` cycle or the cycle after.
- When idle, `ram_addr` holds its last value and `ram_rw`=0.

## Structure
- Add to the shared `define.v`: `MemAddrBus`, `MemDataBus`, state encodings (`ArbIdle`, `ArbRd`, `ArbWr`, `ArbDone`), length codes (`Len1`, `Len2`, `Len4`).
- One sub-module, `ram_byte_pack`: combinational byte-lane insert and sign/zero extension given length, signed and byte index.
- FSM and counters live in `ram_arbiter`.

## Test plan
- IF read at 0x100, RAM bytes 0x13,0x05,0x10,0x00 → addresses 0x100..0x103 in T+1..T+4; `if_ready`=1 and `if_data`=0x00100513 in T+6; `mem_busy`=1 for T+1..T+6.
- Signed byte load at 0x200 = 0x80 → `mem_data_o`=0xFFFFFF80 in T+3; the same load unsigned → 0x00000080.
- Halfword store 0xBEEF to 0x300 → `ram_rw`=1 with (0x300,0xEF) in T+1 and (0x301,0xBE) in T+2; `mem_ready` in T+3.
- IF and MEM request in the same cycle with `FAVOR_MEM`=1 → MEM is served first and `if_busy`=1 throughout; IF starts at MEM DONE+1; `if_data` is correct.
- `rdy` low for 3 cycles during the third byte of a word read → `ram_rw`=0 while paused; address 0x102 is re-driven after resume; final word is correct with latency extended by 4.
- `reset`=0 mid-write → next cycle all outputs 0 and state IDLE; no `ready` pulse; a reissued request completes normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared widths, state encoding, length codes and request payload for the RAM bus arbiter.
package ram_arbiter_pkg;

    localparam int unsigned MemAddrBus = 32;
    localparam int unsigned MemDataBus = 32;
    localparam int unsigned ByteW      = 8;
    localparam int unsigned IdxW       = 3;
    localparam int unsigned LenW       = 3;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbRd   = 2'd1,
        ArbWr   = 2'd2,
        ArbDone = 2'd3
    } arb_state_t;

    localparam logic [LenW-1:0] Len1 = LenW'(1);
    localparam logic [LenW-1:0] Len2 = LenW'(2);
    localparam logic [LenW-1:0] Len4 = LenW'(4);

    // Request captured at grant time; held for the whole transfer.
    typedef struct packed {
        logic [MemAddrBus-1:0] base;
        logic [MemDataBus-1:0] wdata;
        logic [LenW-1:0]       len;
        logic                  sgn;
        logic                  owner_mem;
    } arb_req_t;

    // Only 1, 2 and 4 bytes are real transfer sizes; anything else is a word.
    function automatic logic [LenW-1:0] norm_len(input logic [LenW-1:0] len);
        case (len)
            Len1:    norm_len = Len1;
            Len2:    norm_len = Len2;
            default: norm_len = Len4;
        endcase
    endfunction

    function automatic logic [ByteW-1:0] byte_lane(input logic [MemDataBus-1:0] word,
                                                   input logic [1:0]            lane);
        byte_lane = word[{lane, 3'b000} +: ByteW];
    endfunction

endpackage

// File: rtl/ram_byte_pack.sv
// Inserts a received byte into its little-endian lane and applies load sign/zero extension.
module ram_byte_pack
    import ram_arbiter_pkg::*;
(
    input  logic [MemDataBus-1:0] acc,
    input  logic [ByteW-1:0]      rd_byte,
    input  logic [1:0]            lane,
    input  logic [LenW-1:0]       len,
    input  logic                  sgn,
    output logic [MemDataBus-1:0] data_c
);

    logic [MemDataBus-1:0] merged;

    // Extension only rewrites bits above the transfer size, so partial words stay intact.
    always_comb begin
        merged = acc;
        merged[{lane, 3'b000} +: ByteW] = rd_byte;
        case (len)
            Len1:    data_c = {{(MemDataBus - ByteW){sgn & merged[ByteW-1]}}, merged[ByteW-1:0]};
            Len2:    data_c = {{(MemDataBus - 2 * ByteW){sgn & merged[2*ByteW-1]}},
                               merged[2*ByteW-1:0]};
            default: data_c = merged;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Byte-serial arbiter sharing the external RAM bus between the IF refill port and the MEM stage.
// Grants in IDLE, moves one byte per cycle, and returns a one-cycle ready pulse from DONE.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter bit FAVOR_MEM = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rdy,
    output logic                  ram_rw,
    output logic [MemAddrBus-1:0] ram_addr,
    output logic [ByteW-1:0]      ram_w_data,
    input  logic [ByteW-1:0]      ram_r_data,
    input  logic                  if_read,
    input  logic [MemAddrBus-1:0] if_addr,
    output logic                  if_ready,
    output logic [MemDataBus-1:0] if_data,
    output logic                  if_busy,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MemAddrBus-1:0] mem_addr,
    input  logic [MemDataBus-1:0] mem_data_i,
    input  logic [LenW-1:0]       mem_length,
    input  logic                  mem_signed,
    output logic                  mem_ready,
    output logic [MemDataBus-1:0] mem_data_o,
    output logic                  mem_busy
);

    arb_state_t            state;
    arb_req_t              req;
    logic [IdxW-1:0]       issue_idx;
    logic [IdxW-1:0]       recv_idx;
    logic [IdxW-1:0]       issue_nxt;
    logic [IdxW-1:0]       recv_nxt;
    logic                  cap_pend;
    logic                  ram_rw_q;
    logic [MemDataBus-1:0] acc;
    logic [MemDataBus-1:0] packed_c;
    logic                  mem_req;
    logic                  grant_mem;
    logic                  grant_if;

    // The pause must silence a write in the same cycle, so this is the one unregistered output.
    assign ram_rw = ram_rw_q & rdy;

    assign mem_req   = mem_read | mem_write;
    assign grant_mem = mem_req & (FAVOR_MEM | ~if_read);
    assign grant_if  = if_read & ~grant_mem;
    assign issue_nxt = issue_idx + IdxW'(1);
    assign recv_nxt  = recv_idx + IdxW'(1);

    ram_byte_pack u_pack (
        .acc     (acc),
        .rd_byte (ram_r_data),
        .lane    (recv_idx[1:0]),
        .len     (req.len),
        .sgn     (req.sgn),
        .data_c  (packed_c)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ArbIdle;
            req        <= '0;
            issue_idx  <= '0;
            recv_idx   <= '0;
            cap_pend   <= 1'b0;
            acc        <= '0;
            ram_rw_q   <= 1'b0;
            ram_addr   <= '0;
            ram_w_data <= '0;
            if_ready   <= 1'b0;
            if_data    <= '0;
            if_busy    <= 1'b0;
            mem_ready  <= 1'b0;
            mem_data_o <= '0;
            mem_busy   <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                ArbIdle: begin
                    if (rdy && (grant_mem || grant_if)) begin
                        req.base      <= grant_mem ? mem_addr : if_addr;
                        req.wdata     <= mem_data_i;
                        req.len       <= grant_mem ? norm_len(mem_length) : Len4;
                        req.sgn       <= grant_mem & mem_signed;
                        req.owner_mem <= grant_mem;
                        issue_idx     <= '0;
                        recv_idx      <= '0;
                        cap_pend      <= 1'b0;
                        acc           <= '0;
                        ram_addr      <= grant_mem ? mem_addr : if_addr;
                        if_busy       <= grant_mem;
                        mem_busy      <= grant_if;
                        if (grant_mem && mem_write) begin
                            state      <= ArbWr;
                            ram_rw_q   <= 1'b1;
                            ram_w_data <= byte_lane(mem_data_i, 2'd0);
                        end else begin
                            state <= ArbRd;
                        end
                    end
                end

                ArbRd: begin
                    if (!rdy) begin
                        // Drop the in-flight byte and re-drive the oldest uncaptured address.
                        issue_idx <= recv_idx;
                        ram_addr  <= req.base + MemAddrBus'(recv_idx);
                        cap_pend  <= 1'b0;
                    end else begin
                        if (cap_pend) begin
                            acc      <= packed_c;
                            recv_idx <= recv_nxt;
                            if (recv_nxt == req.len) begin
                                state <= ArbDone;
                                if (req.owner_mem) begin
                                    mem_ready  <= 1'b1;
                                    mem_data_o <= packed_c;
                                end else begin
                                    if_ready <= 1'b1;
                                    if_data  <= packed_c;
                                end
                            end
                        end
                        cap_pend <= (issue_idx < req.len);
                        if (issue_idx < req.len) begin
                            issue_idx <= issue_nxt;
                            if (issue_nxt < req.len) begin
                                ram_addr <= req.base + MemAddrBus'(issue_nxt);
                            end
                        end
                    end
                end

                ArbWr: begin
                    if (rdy) begin
                        if (issue_nxt == req.len) begin
                            state      <= ArbDone;
                            ram_rw_q   <= 1'b0;
                            mem_ready  <= 1'b1;
                            mem_data_o <= '0;
                        end else begin
                            issue_idx  <= issue_nxt;
                            ram_addr   <= req.base + MemAddrBus'(issue_nxt);
                            ram_w_data <= byte_lane(req.wdata, issue_nxt[1:0]);
                        end
                    end
                end

                ArbDone: begin
                    state    <= ArbIdle;
                    if_busy  <= 1'b0;
                    mem_busy <= 1'b0;
                end

                default: state <= ArbIdle;
            endcase
        end
    end

endmodule
